// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: captures every retirement from the commit port into a
// show-ahead FIFO drained over valid/ready, checks ROB tag order, and keeps
// commit/drop counters plus sticky overflow and order-error flags.
// The core is never back-pressured: commits that find no space are dropped.
module commit_trace_buffer #(
  parameter int unsigned WIDTH = 31,
  parameter int unsigned REG   = 4,
  parameter int unsigned ROB   = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      globalReset,
  input  logic                      validCommit,
  input  logic [ROB:0]              commitRob,
  input  logic [REG:0]              commitReg,
  input  logic                      commitWr,
  input  logic [WIDTH:0]            commitValue,
  input  logic                      redirect,
  output logic                      traceValid,
  input  logic                      traceReady,
  output logic [ROB:0]              traceRob,
  output logic [REG:0]              traceReg,
  output logic                      traceWr,
  output logic [WIDTH:0]            traceValue,
  output logic [$clog2(DEPTH):0]    traceLevel,
  output logic [31:0]               commitCount,
  output logic [15:0]               dropCount,
  output logic                      overflow,
  output logic                      orderError
);

  localparam int unsigned PTRW = $clog2(DEPTH);
  localparam int unsigned LVLW = PTRW + 1;
  localparam int unsigned TAGW = ROB + 1;
  localparam int unsigned EW   = (ROB + 1) + (REG + 1) + 1 + (WIDTH + 1);

  logic [EW-1:0]   mem [DEPTH];
  logic [PTRW-1:0] wrPtr;
  logic [PTRW-1:0] rdPtr;
  logic [TAGW-1:0] expTag;

  logic popEn;
  logic hasSpace;
  logic pushEn;
  logic dropEn;

  // Handshake decode; a pop in the same cycle frees a slot even when full
  always_comb begin
    popEn    = traceValid && traceReady;
    hasSpace = (traceLevel < LVLW'(DEPTH)) || popEn;
    pushEn   = validCommit && hasSpace;
    dropEn   = validCommit && !hasSpace;
  end

  assign traceValid = (traceLevel != '0);
  assign {traceRob, traceReg, traceWr, traceValue} = mem[rdPtr];

  // Entry storage; cleared on reset so the head fields read zero
  always_ff @(posedge clk or posedge globalReset) begin
    if (globalReset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (pushEn) begin
      mem[wrPtr] <= {commitRob, commitReg, commitWr, commitValue};
    end
  end

  // Pointers and occupancy; simultaneous push and pop leaves the level unchanged
  always_ff @(posedge clk or posedge globalReset) begin
    if (globalReset) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      traceLevel <= '0;
    end else begin
      if (pushEn) wrPtr <= wrPtr + PTRW'(1);
      if (popEn)  rdPtr <= rdPtr + PTRW'(1);
      case ({pushEn, popEn})
        2'b10:   traceLevel <= traceLevel + LVLW'(1);
        2'b01:   traceLevel <= traceLevel - LVLW'(1);
        default: traceLevel <= traceLevel;
      endcase
    end
  end

  // Commit and drop counters with sticky overflow
  always_ff @(posedge clk or posedge globalReset) begin
    if (globalReset) begin
      commitCount <= '0;
      dropCount   <= '0;
      overflow    <= 1'b0;
    end else begin
      if (pushEn) commitCount <= commitCount + 32'd1;
      if (dropEn) begin
        overflow <= 1'b1;
        if (dropCount != 16'hFFFF) dropCount <= dropCount + 16'd1;
      end
    end
  end

  // Tag order check; resyncs to the observed tag so one fault flags once
  always_ff @(posedge clk or posedge globalReset) begin
    if (globalReset) begin
      expTag     <= '0;
      orderError <= 1'b0;
    end else begin
      if (validCommit && (commitRob != expTag)) orderError <= 1'b1;
      if (redirect) begin
        expTag <= '0;
      end else if (validCommit) begin
        expTag <= commitRob + TAGW'(1);
      end
    end
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed self-checking bench for commit_trace_buffer.
module tb_commit_trace_buffer;

  logic        clk = 1'b0;
  logic        globalReset;
  logic        validCommit;
  logic [2:0]  commitRob;
  logic [4:0]  commitReg;
  logic        commitWr;
  logic [31:0] commitValue;
  logic        redirect;
  logic        traceValid;
  logic        traceReady;
  logic [2:0]  traceRob;
  logic [4:0]  traceReg;
  logic        traceWr;
  logic [31:0] traceValue;
  logic [3:0]  traceLevel;
  logic [31:0] commitCount;
  logic [15:0] dropCount;
  logic        overflow;
  logic        orderError;

  int total = 0;
  int bad   = 0;

  commit_trace_buffer dut (
    .clk(clk), .globalReset(globalReset), .validCommit(validCommit),
    .commitRob(commitRob), .commitReg(commitReg), .commitWr(commitWr),
    .commitValue(commitValue), .redirect(redirect), .traceValid(traceValid),
    .traceReady(traceReady), .traceRob(traceRob), .traceReg(traceReg),
    .traceWr(traceWr), .traceValue(traceValue), .traceLevel(traceLevel),
    .commitCount(commitCount), .dropCount(dropCount), .overflow(overflow),
    .orderError(orderError)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    globalReset = 1'b1;
    validCommit = 1'b0;
    redirect    = 1'b0;
    traceReady  = 1'b0;
    commitRob   = '0;
    commitReg   = '0;
    commitWr    = 1'b0;
    commitValue = '0;
    repeat (2) @(posedge clk);
    #1;
    globalReset = 1'b0;
  endtask

  task automatic commit(input logic [2:0] tag, input logic [31:0] val,
                        input logic wr, input logic rd);
    validCommit = 1'b1;
    commitRob   = tag;
    commitReg   = 5'(tag) + 5'd1;
    commitWr    = wr;
    commitValue = val;
    redirect    = rd;
    tick();
    validCommit = 1'b0;
    redirect    = 1'b0;
  endtask

  initial begin
    // Reset state
    doReset();
    check("rst_valid", 32'(traceValid), 32'd0);
    check("rst_level", 32'(traceLevel), 32'd0);
    check("rst_value", traceValue, 32'd0);
    check("rst_count", commitCount, 32'd0);

    // Streaming with ready held high
    traceReady = 1'b1;
    commit(3'd0, 32'hA, 1'b1, 1'b0);
    check("s1_valid0", 32'(traceValid), 32'd1);
    check("s1_rob0", 32'(traceRob), 32'd0);
    check("s1_val0", traceValue, 32'hA);
    commit(3'd1, 32'hB, 1'b1, 1'b0);
    check("s1_rob1", 32'(traceRob), 32'd1);
    check("s1_val1", traceValue, 32'hB);
    check("s1_lvl1", 32'(traceLevel), 32'd1);
    commit(3'd2, 32'hC, 1'b0, 1'b0);
    check("s1_rob2", 32'(traceRob), 32'd2);
    check("s1_reg2", 32'(traceReg), 32'd3);
    check("s1_val2", traceValue, 32'hC);
    tick();
    check("s1_empty", 32'(traceValid), 32'd0);
    check("s1_count", commitCount, 32'd3);
    check("s1_order", 32'(orderError), 32'd0);

    // Fill with ready low: 8 accepted, 2 dropped
    doReset();
    for (int i = 0; i < 10; i++) begin
      commit(3'(i % 8), 32'h100 + 32'(i), 1'b1, 1'b0);
      if (i == 8) check("s2_drop1", 32'(dropCount), 32'd1);
    end
    check("s2_level", 32'(traceLevel), 32'd8);
    check("s2_drops", 32'(dropCount), 32'd2);
    check("s2_ovf", 32'(overflow), 32'd1);
    check("s2_count", commitCount, 32'd8);
    check("s2_order", 32'(orderError), 32'd0);
    check("s2_head", 32'(traceRob), 32'd0);
    check("s2_headv", traceValue, 32'h100);

    // Full with simultaneous push and pop: no drop
    traceReady = 1'b1;
    commit(3'd2, 32'h200, 1'b0, 1'b0);
    check("s3_level", 32'(traceLevel), 32'd8);
    check("s3_drops", 32'(dropCount), 32'd2);
    check("s3_count", commitCount, 32'd9);
    check("s3_head", 32'(traceRob), 32'd1);

    // Drain remaining entries in order
    for (int k = 1; k < 8; k++) begin
      check("s3_drain_rob", 32'(traceRob), 32'(k));
      check("s3_drain_val", traceValue, 32'h100 + 32'(k));
      tick();
    end
    check("s3_tail_rob", 32'(traceRob), 32'd2);
    check("s3_tail_val", traceValue, 32'h200);
    check("s3_tail_wr", 32'(traceWr), 32'd0);
    tick();
    check("s3_empty", 32'(traceValid), 32'd0);
    check("s3_lvl0", 32'(traceLevel), 32'd0);

    // Out-of-order tag flags once and sticks
    doReset();
    traceReady = 1'b1;
    commit(3'd0, 32'h1, 1'b1, 1'b0);
    commit(3'd1, 32'h2, 1'b1, 1'b0);
    check("s4_ok", 32'(orderError), 32'd0);
    commit(3'd3, 32'h3, 1'b1, 1'b0);
    check("s4_err", 32'(orderError), 32'd1);
    commit(3'd4, 32'h4, 1'b1, 1'b0);
    check("s4_sticky", 32'(orderError), 32'd1);
    check("s4_rob4", 32'(traceRob), 32'd4);

    // Redirect restarts the expected tag at zero
    doReset();
    traceReady = 1'b1;
    for (int i = 0; i < 5; i++) commit(3'(i), 32'h10 + 32'(i), 1'b0, 1'b0);
    commit(3'd5, 32'h55, 1'b1, 1'b1);
    check("s5_rob5", 32'(traceRob), 32'd5);
    check("s5_wr5", 32'(traceWr), 32'd1);
    check("s5_val5", traceValue, 32'h55);
    commit(3'd0, 32'h66, 1'b0, 1'b0);
    check("s5_rob0", 32'(traceRob), 32'd0);
    check("s5_wr0", 32'(traceWr), 32'd0);
    check("s5_order", 32'(orderError), 32'd0);
    check("s5_count", commitCount, 32'd7);

    // Asynchronous reset mid-cycle with four entries queued
    doReset();
    for (int i = 1; i < 5; i++) commit(3'(i), 32'h20 + 32'(i), 1'b1, 1'b0);
    check("s6_level", 32'(traceLevel), 32'd4);
    check("s6_err", 32'(orderError), 32'd1);
    check("s6_head", 32'(traceRob), 32'd1);
    #2;
    globalReset = 1'b1;
    #1;
    check("s6_valid", 32'(traceValid), 32'd0);
    check("s6_lvl0", 32'(traceLevel), 32'd0);
    check("s6_count", commitCount, 32'd0);
    check("s6_errclr", 32'(orderError), 32'd0);
    check("s6_ovf", 32'(overflow), 32'd0);
    check("s6_rob", 32'(traceRob), 32'd0);
    #2;
    globalReset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
